// File: rtl/cache_lookup_ctrl_pkg.sv
// rtl/cache_lookup_ctrl_pkg.sv - shared cache state encoding and address field widths
package cache_lookup_ctrl_pkg;

  localparam int OFFSET_W  = 3;
  localparam int LRU_IDX_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_REQ,
    ST_MISS_WAIT,
    ST_RESPOND
  } state_e;

endpackage

// File: rtl/cache_lookup_ctrl_line_array.sv
// rtl/cache_lookup_ctrl_line_array.sv - direct-mapped valid/tag/data storage, 1R1W
module cache_line_array #(
  parameter int ENTRIES  = 1024,
  parameter int IDX_W    = 10,
  parameter int TAG_W    = 19,
  parameter int WORD_WID = 64
) (
  input  logic                clk_i,
  input  logic                clear_i,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output logic                rd_valid_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic [WORD_WID-1:0] rd_data_o,
  input  logic                we_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic [TAG_W-1:0]    wr_tag_i,
  input  logic [WORD_WID-1:0] wr_data_i
);

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]    tag_mem  [ENTRIES];
  logic [WORD_WID-1:0] data_mem [ENTRIES];

  always_comb begin
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = '0;
    end else if (we_i) begin
      valid_d[wr_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    valid_q <= valid_d;
  end

  // Tag and data need no clear: a line is only trusted through its valid bit.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_mem[wr_idx_i]  <= wr_tag_i;
      data_mem[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_mem[rd_idx_i];
  assign rd_data_o  = data_mem[rd_idx_i];

endmodule

// File: rtl/cache_lookup_ctrl.sv
// rtl/cache_lookup_ctrl.sv - direct-mapped read-only cache lookup/refill controller
module cache_lookup_ctrl
  import cache_lookup_ctrl_pkg::*;
#(
  parameter int CACHE_SIZE = 1024,
  parameter int WORD_WID   = 64,
  parameter int ADDR_WID   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [ADDR_WID-1:0]  req_addr_i,
  output logic                 rsp_valid_o,
  output logic [WORD_WID-1:0]  rsp_data_o,
  output logic                 mem_req_o,
  output logic [ADDR_WID-1:0]  mem_addr_o,
  input  logic                 mem_ack_i,
  input  logic [WORD_WID-1:0]  mem_data_i,
  output logic                 lru_valid_o,
  output logic                 lru_hit_o,
  output logic [LRU_IDX_W-1:0] lru_idx_o
);

  localparam int IDX_W = $clog2(CACHE_SIZE);
  localparam int TAG_W = ADDR_WID - IDX_W - OFFSET_W;
  localparam logic [ADDR_WID-1:0] OFFSET_MASK = ADDR_WID'((1 << OFFSET_W) - 1);

  state_e               state_q, state_d;
  logic [ADDR_WID-1:0]  addr_q, addr_d;
  logic                 hit_q, hit_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WORD_WID-1:0]  rsp_data_q, rsp_data_d;
  logic                 mem_req_q, mem_req_d;
  logic [ADDR_WID-1:0]  mem_addr_q, mem_addr_d;
  logic                 lru_valid_q, lru_valid_d;
  logic                 lru_hit_q, lru_hit_d;
  logic [LRU_IDX_W-1:0] lru_idx_q, lru_idx_d;
  logic                 clear_q, clear_d;

  logic                 accept;
  logic                 lookup_hit;
  logic                 fill_we;
  logic [IDX_W-1:0]     req_idx, cur_idx, rd_idx;
  logic [TAG_W-1:0]     req_tag, cur_tag;
  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag;
  logic [WORD_WID-1:0]  rd_data;

  assign req_idx = req_addr_i[IDX_W+OFFSET_W-1:OFFSET_W];
  assign req_tag = req_addr_i[ADDR_WID-1:IDX_W+OFFSET_W];
  assign cur_idx = addr_q[IDX_W+OFFSET_W-1:OFFSET_W];
  assign cur_tag = addr_q[ADDR_WID-1:IDX_W+OFFSET_W];

  // The read port looks at the incoming address while idle so the hit result
  // is ready for the LRU report in the LOOKUP cycle; the array cannot change
  // between acceptance and LOOKUP.
  assign rd_idx = (state_q == ST_IDLE) ? req_idx : cur_idx;

  cache_line_array #(
    .ENTRIES  (CACHE_SIZE),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W),
    .WORD_WID (WORD_WID)
  ) u_lines (
    .clk_i      (clk_i),
    .clear_i    (clear_q),
    .rd_idx_i   (rd_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (fill_we),
    .wr_idx_i   (cur_idx),
    .wr_tag_i   (cur_tag),
    .wr_data_i  (mem_data_i)
  );

  assign req_ready_o = rst_ni && (state_q == ST_IDLE);
  assign accept      = req_valid_i && req_ready_o;
  // clear_q is still high on the first edge after reset, when the valid bits are being wiped.
  assign lookup_hit  = rd_valid && (rd_tag == req_tag) && !clear_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hit_d       = hit_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    lru_valid_d = 1'b0;
    lru_hit_d   = lru_hit_q;
    lru_idx_d   = lru_idx_q;
    clear_d     = 1'b0;
    fill_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d      = req_addr_i;
          hit_d       = lookup_hit;
          lru_valid_d = 1'b1;
          lru_hit_d   = lookup_hit;
          lru_idx_d   = LRU_IDX_W'(req_idx);
          state_d     = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = rd_data;
          state_d     = ST_RESPOND;
        end else begin
          mem_req_d   = 1'b1;
          mem_addr_d  = addr_q & ~OFFSET_MASK;
          state_d     = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ, ST_MISS_WAIT: begin
        if (mem_ack_i) begin
          fill_we     = 1'b1;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = mem_data_i;
          state_d     = ST_RESPOND;
        end else begin
          state_d     = ST_MISS_WAIT;
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      hit_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      lru_valid_q <= 1'b0;
      lru_hit_q   <= 1'b0;
      lru_idx_q   <= '0;
      clear_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      hit_q       <= hit_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      lru_valid_q <= lru_valid_d;
      lru_hit_q   <= lru_hit_d;
      lru_idx_q   <= lru_idx_d;
      clear_q     <= clear_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign lru_valid_o = lru_valid_q;
  assign lru_hit_o   = lru_hit_q;
  assign lru_idx_o   = lru_idx_q;

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// tb/tb_cache_lookup_ctrl.sv - directed self-checking bench for cache_lookup_ctrl
module tb_cache_lookup_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        rsp_valid_o;
  logic [63:0] rsp_data_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [63:0] mem_data_i;
  logic        lru_valid_o;
  logic        lru_hit_o;
  logic [9:0]  lru_idx_o;

  int checks = 0;
  int errors = 0;

  cache_lookup_ctrl #(
    .CACHE_SIZE (1024),
    .WORD_WID   (64),
    .ADDR_WID   (32)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_data_i  (mem_data_i),
    .lru_valid_o (lru_valid_o),
    .lru_hit_o   (lru_hit_o),
    .lru_idx_o   (lru_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at a falling edge with the controller idle.
  task automatic do_read(input string name, input logic [31:0] addr, input bit exp_hit,
                         input logic [9:0] exp_idx, input logic [63:0] data, input int delay);
    check({name, ".ready_idle"}, req_ready_o, 1);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    check({name, ".lru_valid"}, lru_valid_o, 1);
    check({name, ".lru_hit"}, lru_hit_o, exp_hit);
    check({name, ".lru_idx"}, lru_idx_o, exp_idx);
    check({name, ".ready_busy"}, req_ready_o, 0);
    check({name, ".rsp_early"}, rsp_valid_o, 0);
    @(negedge clk_i);
    check({name, ".lru_pulse"}, lru_valid_o, 0);
    if (exp_hit) begin
      check({name, ".hit_rsp_valid"}, rsp_valid_o, 1);
      check({name, ".hit_rsp_data"}, rsp_data_o, data);
      check({name, ".hit_no_mem"}, mem_req_o, 0);
    end else begin
      check({name, ".mem_req"}, mem_req_o, 1);
      check({name, ".mem_addr"}, mem_addr_o, {addr[31:3], 3'b000});
      check({name, ".miss_rsp_early"}, rsp_valid_o, 0);
      for (int i = 0; i < delay; i++) begin
        @(negedge clk_i);
        check({name, ".mem_req_hold"}, mem_req_o, 1);
        check({name, ".rsp_wait"}, rsp_valid_o, 0);
      end
      mem_ack_i  = 1'b1;
      mem_data_i = data;
      @(negedge clk_i);
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
      check({name, ".miss_rsp_valid"}, rsp_valid_o, 1);
      check({name, ".miss_rsp_data"}, rsp_data_o, data);
      check({name, ".mem_req_drop"}, mem_req_o, 0);
    end
    @(negedge clk_i);
    check({name, ".rsp_pulse"}, rsp_valid_o, 0);
    check({name, ".ready_again"}, req_ready_o, 1);
  endtask

  initial begin
    bit rsp_seen;
    int accepts;
    int rsps;
    bit busy_ready;
    bit bad_data;

    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    mem_ack_i   = 1'b0;
    mem_data_i  = '0;
    repeat (3) @(negedge clk_i);

    check("rst.req_ready", req_ready_o, 0);
    check("rst.rsp_valid", rsp_valid_o, 0);
    check("rst.rsp_data", rsp_data_o, 0);
    check("rst.mem_req", mem_req_o, 0);
    check("rst.mem_addr", mem_addr_o, 0);
    check("rst.lru_valid", lru_valid_o, 0);
    check("rst.lru_hit", lru_hit_o, 0);
    check("rst.lru_idx", lru_idx_o, 0);
    rst_ni = 1'b1;
    #1;
    check("rst.ready_after_release", req_ready_o, 1);
    @(negedge clk_i);

    do_read("miss_1000", 32'h0000_1000, 1'b0, 10'h200, 64'hDEAD_BEEF, 1);
    do_read("hit_1004", 32'h0000_1004, 1'b1, 10'h200, 64'hDEAD_BEEF, 0);
    do_read("miss_3000", 32'h0000_3000, 1'b0, 10'h200, 64'h1111_2222_3333_4444, 0);
    do_read("remiss_1000", 32'h0000_1000, 1'b0, 10'h200, 64'h5555_6666, 5);
    do_read("hit_1000", 32'h0000_1000, 1'b1, 10'h200, 64'h5555_6666, 0);
    do_read("miss_0008", 32'h0000_000C, 1'b0, 10'h001, 64'hA5A5_0001, 1);
    do_read("hit_0008", 32'h0000_0008, 1'b1, 10'h001, 64'hA5A5_0001, 0);
    do_read("hit_1000b", 32'h0000_1000, 1'b1, 10'h200, 64'h5555_6666, 0);

    // Reset while a refill is outstanding.
    req_valid_i = 1'b1;
    req_addr_i  = 32'h0000_5000;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    check("rstmid.lru_hit", lru_hit_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    check("rstmid.mem_req_wait", mem_req_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("rstmid.mem_req_drop", mem_req_o, 0);
    check("rstmid.ready_low", req_ready_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mem_ack_i  = 1'b1;
    mem_data_i = 64'hBAD0_BAD0;
    rsp_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (rsp_valid_o || mem_req_o) rsp_seen = 1'b1;
    end
    mem_data_i = '0;
    check("rstmid.no_response", rsp_seen, 0);
    do_read("post_rst_1000", 32'h0000_1000, 1'b0, 10'h200, 64'h0123_4567_89AB_CDEF, 2);

    // Request held continuously; hits cycle IDLE/LOOKUP/RESPOND every 3 cycles.
    accepts    = 0;
    rsps       = 0;
    busy_ready = 1'b0;
    bad_data   = 1'b0;
    req_valid_i = 1'b1;
    req_addr_i  = 32'h0000_1000;
    for (int k = 0; k < 30; k++) begin
      if (req_ready_o) accepts++;
      if (rsp_valid_o) begin
        rsps++;
        if (rsp_data_o !== 64'h0123_4567_89AB_CDEF) bad_data = 1'b1;
      end
      if (req_ready_o && (lru_valid_o || rsp_valid_o || mem_req_o)) busy_ready = 1'b1;
      if (k == 29) req_valid_i = 1'b0;
      @(negedge clk_i);
    end
    check("stream.accepts", accepts, 10);
    check("stream.responses", rsps, 10);
    check("stream.ready_only_idle", busy_ready, 0);
    check("stream.data", bad_data, 0);
    check("stream.idle_after", req_ready_o, 1);
    check("stream.no_trailing_rsp", rsp_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
